// File: rtl/mips_main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// The fetch unit and the ALU control decode the same PC_SEL, ALUSrcB and ALUOp values.
package mips_main_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JR        = 4'd11,
        S_ADDI_EXEC = 4'd12,
        S_ADDI_WB   = 4'd13,
        S_EXCEPTION = 4'd14
    } state_t;

    typedef enum logic [2:0] {
        PCSEL_ALU_OUT = 3'd0,
        PCSEL_ALU_REG = 3'd1,
        PCSEL_JUMP    = 3'd2,
        PCSEL_REG1    = 3'd3,
        PCSEL_VECTOR  = 3'd4
    } pc_sel_t;

    typedef enum logic [1:0] {
        SRCB_REG_B   = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       ir_en;
        logic       epc_en;
        pc_sel_t    pc_sel;
        logic       mem_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Only signed add/sub trap on overflow; addu/subu and logic ops never do.
    function automatic logic is_trapping_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB);
    endfunction

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Moore output map from control state to the datapath strobe bundle.
// Zero is the single Mealy input, gating the PC update while branching.
module mips_ctrl_output_decode
    import mips_main_control_fsm_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.ir_en     = 1'b1;
                ctrl.pc_load   = 1'b1;
                ctrl.pc_sel    = PCSEL_ALU_OUT;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.iord = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.iord   = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_sel    = PCSEL_ALU_REG;
                ctrl.pc_load   = zero;
            end
            S_JUMP: begin
                ctrl.pc_sel  = PCSEL_JUMP;
                ctrl.pc_load = 1'b1;
            end
            S_JR: begin
                ctrl.pc_sel  = PCSEL_REG1;
                ctrl.pc_load = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_we = 1'b1;
            end
            // PC already holds fault address + 4 from FETCH, so EPC latches that.
            S_EXCEPTION: begin
                ctrl.epc_en  = 1'b1;
                ctrl.pc_sel  = PCSEL_VECTOR;
                ctrl.pc_load = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multi-cycle MIPS main control: state register and next-state decode.
// Outputs come from mips_ctrl_output_decode so they follow the state directly.
//
// state       | meaning
// IDLE        | reset / parked, all strobes low
// FETCH       | IR <= mem[PC], PC <= PC + 4
// DECODE      | read regs, branch target into ALU_REG_OUT
// MEM_ADDR    | base + imm for lw/sw
// MEM_READ    | mem[ALU_OUT] into MDR
// MEM_WB      | rt <= MDR
// MEM_WRITE   | mem[ALU_OUT] <= B
// EXECUTE     | R-type ALU op
// ALU_WB      | rd <= ALU result
// BRANCH      | beq compare, PC <= target if Zero
// JUMP        | PC <= jump concat
// JR          | PC <= rs
// ADDI_EXEC   | A + sign-ext imm
// ADDI_WB     | rt <= ALU result
// EXCEPTION   | EPC <= PC, PC <= vector
module mips_main_control_fsm
    import mips_main_control_fsm_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic [FUNCT_WIDTH-1:0]  Funct,
    input  logic                    Zero,
    input  logic                    Overflow,
    output logic                    PC_LOAD,
    output logic                    IorD,
    output logic                    IR_EN,
    output logic                    EPC_EN,
    output logic [2:0]              PC_SEL,
    output logic                    MEM_WE,
    output logic                    REG_WE,
    output logic                    RegDst,
    output logic                    MemtoReg,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [STATE_WIDTH-1:0]  STATE
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    logic [5:0] funct6;
    assign funct6 = 6'(Funct);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (Opcode == OPCODE_WIDTH'(OP_LW) || Opcode == OPCODE_WIDTH'(OP_SW)) begin
                    state_d = S_MEM_ADDR;
                end else if (Opcode == OPCODE_WIDTH'(OP_RTYPE)) begin
                    state_d = (funct6 == FN_JR) ? S_JR : S_EXECUTE;
                end else if (Opcode == OPCODE_WIDTH'(OP_BEQ)) begin
                    state_d = S_BRANCH;
                end else if (Opcode == OPCODE_WIDTH'(OP_J)) begin
                    state_d = S_JUMP;
                end else if (Opcode == OPCODE_WIDTH'(OP_ADDI)) begin
                    state_d = S_ADDI_EXEC;
                end else begin
                    state_d = S_EXCEPTION;
                end
            end
            // Only lw and sw reach MEM_ADDR, so anything but lw is a store.
            S_MEM_ADDR: state_d = (Opcode == OPCODE_WIDTH'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_EXECUTE: begin
                if (Overflow && is_trapping_funct(funct6)) begin
                    state_d = S_EXCEPTION;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_ADDI_EXEC: state_d = Overflow ? S_EXCEPTION : S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH,
            S_JUMP, S_JR, S_ADDI_WB, S_EXCEPTION: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    mips_ctrl_output_decode u_output_decode (
        .state (state_q),
        .zero  (Zero),
        .ctrl  (ctrl)
    );

    assign PC_LOAD  = ctrl.pc_load;
    assign IorD     = ctrl.iord;
    assign IR_EN    = ctrl.ir_en;
    assign EPC_EN   = ctrl.epc_en;
    assign PC_SEL   = ctrl.pc_sel;
    assign MEM_WE   = ctrl.mem_we;
    assign REG_WE   = ctrl.reg_we;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign STATE    = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Bench for mips_main_control_fsm: directed and random instructions checked
// cycle by cycle against a per-instruction control-sequence model.
module tb_mips_main_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Zero = 1'b0;
    logic       Overflow = 1'b0;
    logic       PC_LOAD, IorD, IR_EN, EPC_EN, MEM_WE, REG_WE, RegDst, MemtoReg, ALUSrcA;
    logic [2:0] PC_SEL;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] STATE;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       pc_load;
        logic       iord;
        logic       ir_en;
        logic       epc_en;
        logic [2:0] pc_sel;
        logic       mem_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } exp_t;

    exp_t exp_q[$];

    mips_main_control_fsm #(
        .OPCODE_WIDTH (6),
        .FUNCT_WIDTH  (6),
        .STATE_WIDTH  (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Opcode   (Opcode),
        .Funct    (Funct),
        .Zero     (Zero),
        .Overflow (Overflow),
        .PC_LOAD  (PC_LOAD),
        .IorD     (IorD),
        .IR_EN    (IR_EN),
        .EPC_EN   (EPC_EN),
        .PC_SEL   (PC_SEL),
        .MEM_WE   (MEM_WE),
        .REG_WE   (REG_WE),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t v(input logic pl, input logic iord, input logic ir, input logic epc,
                               input logic [2:0] psel, input logic mwe, input logic rwe,
                               input logic rd, input logic m2r, input logic sa,
                               input logic [1:0] sb, input logic [1:0] op);
        exp_t e;
        e = '{pl, iord, ir, epc, psel, mwe, rwe, rd, m2r, sa, sb, op};
        return e;
    endfunction

    function automatic exp_t observed();
        return '{PC_LOAD, IorD, IR_EN, EPC_EN, PC_SEL, MEM_WE, REG_WE, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, ALUOp};
    endfunction

    // Expected per-cycle controls for one whole instruction, FETCH first.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        exp_t trap;
        trap = v(1, 0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        exp_q.delete();
        exp_q.push_back(v(1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd1, 2'd0));
        exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd3, 2'd0));
        case (op)
            6'h23: begin
                exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0));
                exp_q.push_back(v(0, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
                exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0));
            end
            6'h2B: begin
                exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0));
                exp_q.push_back(v(0, 1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0));
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    exp_q.push_back(v(1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0));
                end else begin
                    exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 2'd0, 2'd2));
                    if (ov && (fn == 6'h20 || fn == 6'h22)) exp_q.push_back(trap);
                    else exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0));
                end
            end
            6'h04: exp_q.push_back(v(z, 0, 0, 0, 3'd1, 0, 0, 0, 0, 1, 2'd0, 2'd1));
            6'h02: exp_q.push_back(v(1, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            6'h08: begin
                exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 2'd2, 2'd0));
                if (ov) exp_q.push_back(trap);
                else exp_q.push_back(v(0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
            end
            default: exp_q.push_back(trap);
        endcase
    endtask

    task automatic check(input string tag, input int cyc, input exp_t e);
        exp_t o;
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    // Runs up to max_cyc cycles of one instruction; DUT must be in FETCH on entry.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input int max_cyc);
        build(op, fn, z, ov);
        Opcode = op;
        Funct = fn;
        Zero = z;
        Overflow = ov;
        for (int i = 0; i < exp_q.size() && i < max_cyc; i++) begin
            @(negedge CLK);
            check(tag, i + 1, exp_q[i]);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("idle_after_rst", 0, '0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[7];
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h08, 6'h24, 6'h2A, 6'h00};

        repeat (2) begin
            @(negedge CLK);
            check("reset_zero", 0, '0);
        end
        release_reset();

        run_instr("lw", 6'h23, 6'h00, 0, 0, 99);
        run_instr("beq_taken", 6'h04, 6'h00, 1, 0, 99);
        run_instr("beq_not", 6'h04, 6'h00, 0, 0, 99);
        run_instr("j", 6'h02, 6'h00, 0, 0, 99);
        run_instr("jr", 6'h00, 6'h08, 0, 1, 99);
        run_instr("add_ovf", 6'h00, 6'h20, 0, 1, 99);
        run_instr("addu_ovf", 6'h00, 6'h21, 0, 1, 99);
        run_instr("sub_ovf", 6'h00, 6'h22, 0, 1, 99);
        run_instr("add_ok", 6'h00, 6'h20, 0, 0, 99);
        run_instr("undef_3f", 6'h3F, 6'h00, 0, 0, 99);
        run_instr("sw", 6'h2B, 6'h00, 0, 1, 99);
        run_instr("addi_ok", 6'h08, 6'h00, 0, 0, 99);
        run_instr("addi_ovf", 6'h08, 6'h00, 0, 1, 99);

        // Interrupt an R-type in EXECUTE with a 3-cycle reset.
        run_instr("rtype_pre_rst", 6'h00, 6'h20, 0, 0, 2);
        @(negedge CLK);
        check("execute_pre_rst", 3, v(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 2'd0, 2'd2));
        #1 RST = 1'b1;
        #1 check("async_rst_zero", 0, '0);
        repeat (3) begin
            @(negedge CLK);
            check("rst_held_zero", 0, '0);
        end
        release_reset();
        run_instr("post_rst_fetch", 6'h02, 6'h00, 0, 0, 99);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            fn = fns[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
            run_instr("random", op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 99);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
